down_timer: RTL and testbench
=============================

// Module: down_timer
// PURPOSE
//  Loadable down-counting timer; the counting-down counterpart of the up-counter.
//  Accepts a period via a valid/ready load handshake and decrements on cnt_en.
//  Emits a one-cycle terminal-count pulse, in one-shot or auto-reload mode.
//  Used by control blocks to time waits and intervals without hand-rolled counters.
// PARAMETERS
//  CNT_WIDTH  4  width of period / live count
//  EVT_WIDTH  8  width of saturating expiry-event counter
// PORTS
//  cnt_clk   in   1          single clock, rising edge
//  cnt_rst   in   1          asynchronous, active-high reset
//  ld_valid  in   1          load request
//  ld_ready  out  1          load accept; handshake = ld_valid & ld_ready
//  ld_value  in   CNT_WIDTH  period value N
//  ld_auto   in   1          1 = auto-reload, 0 = one-shot (sampled at load)
//  cnt_en    in   1          decrement qualifier
//  abort     in   1          cancel the running count
//  cnt_o     out  CNT_WIDTH  live count
//  busy      out  1          high while in RUN
//  tc_o      out  1          registered terminal-count pulse
//  evt_cnt_o out  EVT_WIDTH  expiries since last load, saturating
// BEHAVIOUR
//  Reset (async, active-high):
//   - state=IDLE; cnt_o=0; reload=0; auto=0.
//   - busy=0; tc_o=0; evt_cnt_o=0; ld_ready=1.
//  FSM, states IDLE and RUN. ld_ready = (state==IDLE); busy = (state==RUN).
//  IDLE:
//   - On handshake: cnt_o<=ld_value, reload<=ld_value, auto<=ld_auto, evt_cnt_o<=0, go to RUN.
//   - abort and cnt_en are ignored.
//  RUN, priority abort > expiry > decrement:
//   - abort: go to IDLE, cnt_o holds, no tc_o, evt_cnt_o unchanged.
//   - cnt_en & cnt_o!=0: cnt_o<=cnt_o-1.
//   - cnt_en & cnt_o==0 (expiry): tc_o<=1 for one cycle; evt_cnt_o<=evt_cnt_o+1,
//     saturating at all-ones.
//     - auto=1: cnt_o<=reload, stay in RUN.
//     - auto=0: go to IDLE, cnt_o stays 0.
//   - cnt_en=0: all state holds.
//  Period: N+1 enabled cycles from load to tc_o. N=0 expires on the first enabled cycle.
//   Auto mode with reload=0 holds tc_o high on every enabled cycle.
//  tc_o: registered, deasserts the next cycle unless another expiry occurs.
//   - One-shot: tc_o rises in the same cycle busy falls and ld_ready rises.
//   - A load accepted in that cycle is legal and starts a new period.
//  ld_value is sampled only at the handshake. Changes to ld_auto while running have no effect.
//  Async reset mid-RUN clears everything immediately; no tc_o is produced.
//  Arithmetic: unsigned, CNT_WIDTH bits. A decrement never wraps, because zero is handled as expiry.
// STRUCTURE
//  - Package down_timer_pkg: typedef enum logic {TMR_IDLE, TMR_RUN} tmr_state_e.
//  - One sub-module, sat_counter #(WIDTH): clr, inc, q. Saturates at all-ones; instantiated for evt_cnt_o.
//  - All other logic lives in a single always_ff block with asynchronous reset, plus combinational ld_ready/busy.
// TESTING (CNT_WIDTH=4, EVT_WIDTH=8 unless noted)
//  1. Load 5 one-shot, cnt_en=1; assert cnt_rst at cnt_o=3
//     -> all outputs reset to 0 before the next edge, ld_ready=1, no tc_o.
//  2. Load 3 one-shot, cnt_en=1 constant
//     -> cnt_o 3,2,1,0; tc_o=1 for 1 cycle after the 4th enabled edge.
//     -> busy=0 and evt_cnt_o=1 in that cycle.
//  3. Load 2 auto, cnt_en=1 for 9 edges
//     -> tc_o pulses on edges 3, 6 and 9; cnt_o reloads to 2; evt_cnt_o=3; busy stays 1.
//  4. Load 1 one-shot, cnt_en pattern 1,0,0,1
//     -> cnt_o 0 after edge 1, held through the gaps; tc_o after edge 4 only.
//  5. Load 0 one-shot; at the first enabled edge drive abort=1
//     -> IDLE, no tc_o, evt_cnt_o=0, cnt_o=0.
//  6. EVT_WIDTH=2: load 0 auto, cnt_en=1 for 6 edges
//     -> tc_o high 6 cycles; evt_cnt_o 1,2,3,3,3,3.
//     -> Then abort and reload 4: evt_cnt_o=0.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types for the loadable down-counting timer.
package down_timer_pkg;
    typedef enum logic {TMR_IDLE, TMR_RUN} tmr_state_e;
endpackage

// File: rtl/down_timer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {WIDTH{1'b1}})) begin
            r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign q = r_q;
endmodule

// File: rtl/down_timer.sv
// Loadable down timer: N+1 enabled cycles per period, one-shot or auto-reload,
// with a registered terminal-count pulse and a saturating expiry counter.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int CNT_WIDTH = 4,
    parameter int EVT_WIDTH = 8
) (
    input  logic                 cnt_clk,
    input  logic                 cnt_rst,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [CNT_WIDTH-1:0] ld_value,
    input  logic                 ld_auto,
    input  logic                 cnt_en,
    input  logic                 abort,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 busy,
    output logic                 tc_o,
    output logic [EVT_WIDTH-1:0] evt_cnt_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    tmr_state_e           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_reload;
    logic                 r_auto;
    logic                 r_tc;
    logic                 w_load;
    logic                 w_expire;

    assign ld_ready = (r_state == TMR_IDLE);
    assign busy     = (r_state == TMR_RUN);
    assign w_load   = ld_valid && ld_ready;
    // Zero is the expiry point, so the decrement path never sees zero.
    assign w_expire = busy && !abort && cnt_en && (r_cnt == '0);

    always_ff @(posedge cnt_clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            r_state  <= TMR_IDLE;
            r_cnt    <= '0;
            r_reload <= '0;
            r_auto   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            case (r_state)
                TMR_IDLE: begin
                    if (ld_valid) begin
                        r_cnt    <= ld_value;
                        r_reload <= ld_value;
                        r_auto   <= ld_auto;
                        r_state  <= TMR_RUN;
                    end
                end
                TMR_RUN: begin
                    if (abort) begin
                        r_state <= TMR_IDLE;
                    end else if (cnt_en) begin
                        if (r_cnt == '0) begin
                            r_tc <= 1'b1;
                            if (r_auto) begin
                                r_cnt <= r_reload;
                            end else begin
                                r_state <= TMR_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                default: r_state <= TMR_IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(EVT_WIDTH)) u_evt (
        .clk (cnt_clk),
        .rst (cnt_rst),
        .clr (w_load),
        .inc (w_expire),
        .q   (evt_cnt_o)
    );

    assign cnt_o = r_cnt;
    assign tc_o  = r_tc;
endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: vector table for the main sequences plus
// hand-written reset and event-saturation sequences.
module tb_down_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_valid = 1'b0;
    logic [3:0] ld_value = 4'd0;
    logic       ld_auto = 1'b0;
    logic       cnt_en = 1'b0;
    logic       abort = 1'b0;

    logic       ld_ready, busy, tc_o;
    logic [3:0] cnt_o;
    logic [7:0] evt_cnt_o;
    logic       ld_ready2, busy2, tc2;
    logic [3:0] cnt2;
    logic [1:0] evt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    down_timer #(.CNT_WIDTH(4), .EVT_WIDTH(8)) dut (
        .cnt_clk(clk), .cnt_rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_value(ld_value), .ld_auto(ld_auto), .cnt_en(cnt_en), .abort(abort),
        .cnt_o(cnt_o), .busy(busy), .tc_o(tc_o), .evt_cnt_o(evt_cnt_o)
    );

    down_timer #(.CNT_WIDTH(4), .EVT_WIDTH(2)) dut2 (
        .cnt_clk(clk), .cnt_rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready2),
        .ld_value(ld_value), .ld_auto(ld_auto), .cnt_en(cnt_en), .abort(abort),
        .cnt_o(cnt2), .busy(busy2), .tc_o(tc2), .evt_cnt_o(evt2)
    );

    typedef struct {
        logic       v;
        logic [3:0] val;
        logic       au;
        logic       en;
        logic       ab;
        logic [3:0] e_cnt;
        logic       e_busy;
        logic       e_tc;
        logic [7:0] e_evt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] val, input logic au,
                         input logic en, input logic ab);
        ld_valid = v; ld_value = val; ld_auto = au; cnt_en = en; abort = ab;
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] val, input logic au,
                                input logic en, input logic ab, input logic [3:0] c,
                                input logic b, input logic t, input logic [7:0] e);
        vec_t r;
        r.v = v; r.val = val; r.au = au; r.en = en; r.ab = ab;
        r.e_cnt = c; r.e_busy = b; r.e_tc = t; r.e_evt = e;
        return r;
    endfunction

    initial begin
        // Load 3 one-shot, continuous enable.
        tbl.push_back(mk(1, 3, 0, 1, 0, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
        // Load 2 auto in the tc cycle, then 9 enabled edges.
        tbl.push_back(mk(1, 2, 1, 1, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 9, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 3));
        // Abort holds count and event total.
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 0, 3));
        // Load 1 one-shot, enable 1,0,0,1; ld_auto toggled while running.
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1));
        // Idle ignores enable and abort.
        tbl.push_back(mk(0, 7, 0, 1, 1, 0, 0, 0, 1));
        // Load 0 one-shot, abort on the first enabled edge.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

        // Reset state.
        #2;
        check("rst_cnt", cnt_o, 0);
        check("rst_ready", ld_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tc", tc_o, 0);
        check("rst_evt", evt_cnt_o, 0);
        step();
        rst = 1'b0;
        step();

        // Async reset mid-run at cnt_o=3.
        drive(1, 5, 0, 1, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        step();
        check("mid_cnt_before", cnt_o, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt", cnt_o, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", ld_ready, 1);
        check("arst_tc", tc_o, 0);
        check("arst_evt", evt_cnt_o, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_tc", tc_o, 0);
        check("post_rst_busy", busy, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].val, tbl[i].au, tbl[i].en, tbl[i].ab);
            step();
            check($sformatf("v%0d_cnt", i), cnt_o, tbl[i].e_cnt);
            check($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("v%0d_ready", i), ld_ready, !tbl[i].e_busy);
            check($sformatf("v%0d_tc", i), tc_o, tbl[i].e_tc);
            check($sformatf("v%0d_evt", i), evt_cnt_o, tbl[i].e_evt);
        end

        // 2-bit event counter: load 0 auto, six enabled edges.
        drive(1, 0, 1, 1, 0);
        step();
        check("sat_load_busy", busy2, 1);
        check("sat_load_evt", evt2, 0);
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("sat%0d_tc", k), tc2, 1);
            check($sformatf("sat%0d_evt", k), evt2, (k < 3) ? k + 1 : 3);
            check($sformatf("sat%0d_cnt", k), cnt2, 0);
        end
        drive(0, 0, 0, 1, 1);
        step();
        check("sat_abort_busy", busy2, 0);
        check("sat_abort_tc", tc2, 0);
        check("sat_abort_evt", evt2, 3);
        drive(1, 4, 0, 0, 0);
        step();
        check("sat_reload_evt", evt2, 0);
        check("sat_reload_cnt", cnt2, 4);
        drive(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
